// File: rtl/cw305_heep_prog_bridge_pkg.sv
// rtl/cw305_heep_prog_bridge_pkg.sv - shared status bit indices and OBI word helpers
package cw305_heep_prog_bridge_pkg;

    localparam int STATUS_PROG_EN     = 0;
    localparam int STATUS_INSTR_VALID = 1;
    localparam int STATUS_ADDR_VALID  = 2;

    localparam int          WORD_BYTES = 4;
    localparam logic [3:0]  OBI_BE_ALL = 4'hF;

    function automatic logic is_misaligned(input logic [1:0] addr_lsbs);
        return addr_lsbs != 2'b00;
    endfunction

endpackage

// File: rtl/cw305_heep_prog_bridge.sv
// rtl/cw305_heep_prog_bridge.sv - USB register to X-HEEP OBI programming bridge
module cw305_heep_prog_bridge
    import cw305_heep_prog_bridge_pkg::*;
#(
    parameter int pINSTR_WIDTH = 32,
    parameter int pCNT_WIDTH   = 16
) (
    input  logic                    usb_clk,
    input  logic                    reset_i,
    input  logic [7:0]              I_status,
    input  logic [pINSTR_WIDTH-1:0] I_instruction,
    input  logic [pINSTR_WIDTH-1:0] I_address,
    output logic                    O_reset_instr_valid,
    output logic                    O_reset_new_addr_valid,
    output logic                    O_obi_req,
    input  logic                    I_obi_gnt,
    output logic [pINSTR_WIDTH-1:0] O_obi_addr,
    output logic                    O_obi_we,
    output logic [3:0]              O_obi_be,
    output logic [pINSTR_WIDTH-1:0] O_obi_wdata,
    input  logic                    I_obi_rvalid,
    output logic                    O_busy,
    output logic [pCNT_WIDTH-1:0]   O_word_count,
    output logic                    O_error
);

    localparam logic [2:0] IDLE           = 3'd0;
    localparam logic [2:0] LOAD_ADDR      = 3'd1;
    localparam logic [2:0] REQ            = 3'd2;
    localparam logic [2:0] RESP           = 3'd3;
    localparam logic [2:0] CLR_INSTR      = 3'd4;
    localparam logic [2:0] WAIT_ADDR_LOW  = 3'd5;
    localparam logic [2:0] WAIT_INSTR_LOW = 3'd6;

    logic [2:0]              state;
    logic [pINSTR_WIDTH-1:0] pointer;
    logic [pINSTR_WIDTH-1:0] wdata_q;
    logic [pCNT_WIDTH-1:0]   word_count;
    logic                    error;

    logic prog_en;
    logic instr_valid;
    logic addr_valid;
    logic unused_status;

    assign prog_en       = I_status[STATUS_PROG_EN];
    assign instr_valid   = I_status[STATUS_INSTR_VALID];
    assign addr_valid    = I_status[STATUS_ADDR_VALID];
    assign unused_status = ^I_status[7:3];

    always_ff @(posedge usb_clk) begin
        if (reset_i) begin
            state      <= IDLE;
            pointer    <= '0;
            wdata_q    <= '0;
            word_count <= '0;
            error      <= 1'b0;
        end else begin
            case (state)
                // prog_enable gates only new work; in-flight writes run to completion
                IDLE: begin
                    if (prog_en) begin
                        if (addr_valid) begin
                            state <= LOAD_ADDR;
                        end else if (instr_valid) begin
                            wdata_q <= I_instruction;
                            state   <= REQ;
                        end
                    end
                end
                LOAD_ADDR: begin
                    pointer    <= {I_address[pINSTR_WIDTH-1:2], 2'b00};
                    error      <= error | is_misaligned(I_address[1:0]);
                    word_count <= '0;
                    state      <= WAIT_ADDR_LOW;
                end
                // hold off until the register block has dropped the flag, else it reloads
                WAIT_ADDR_LOW: begin
                    if (!addr_valid) begin
                        state <= IDLE;
                    end
                end
                REQ: begin
                    if (I_obi_gnt) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (I_obi_rvalid) begin
                        pointer    <= pointer + pINSTR_WIDTH'(WORD_BYTES);
                        word_count <= word_count + 1'b1;
                        state      <= CLR_INSTR;
                    end
                end
                CLR_INSTR: begin
                    state <= WAIT_INSTR_LOW;
                end
                WAIT_INSTR_LOW: begin
                    if (!instr_valid) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // bus fields read as zero outside a request so reset and idle look identical
    always_comb begin
        O_obi_req              = (state == REQ);
        O_obi_we               = O_obi_req;
        O_obi_be               = O_obi_req ? OBI_BE_ALL : 4'h0;
        O_obi_addr             = O_obi_req ? pointer : '0;
        O_obi_wdata            = O_obi_req ? wdata_q : '0;
        O_reset_instr_valid    = (state != CLR_INSTR);
        O_reset_new_addr_valid = (state != LOAD_ADDR);
        O_busy                 = (state != IDLE);
        O_word_count           = word_count;
        O_error                = error;
    end

endmodule

// File: doc/cw305_heep_prog_bridge.md
Name: cw305_heep_prog_bridge

Overview:
Programming bridge that consumes the instruction, address and status registers written over USB. It turns each valid instruction into one 32-bit OBI write into X-HEEP memory.
- An auto-incrementing word pointer is loaded from the programmed address.
- Active-low clear strobes drop the status valid flags back to the register block, which releases the host-side polling loop.
- Sits between the USB register block and the X-HEEP bus/memory port.

Parameters:
pINSTR_WIDTH, 32, width of instruction, address and OBI data/address buses
pCNT_WIDTH, 16, width of the programmed-word counter

Ports:
usb_clk  input  1  sole clock (same domain as register block write logic)
reset_i  input  1  synchronous, active-high reset
I_status  input  8  status register; [0]=prog_enable, [1]=instr_valid, [2]=addr_valid, others ignored
I_instruction  input  pINSTR_WIDTH  word to write
I_address  input  pINSTR_WIDTH  new start byte address
O_reset_instr_valid  output  1  active-low one-cycle strobe: clear status[1]
O_reset_new_addr_valid  output  1  active-low one-cycle strobe: clear status[2]
O_obi_req  output  1  OBI request
I_obi_gnt  input  1  OBI grant
O_obi_addr  output  pINSTR_WIDTH  OBI byte address (word aligned)
O_obi_we  output  1  OBI write enable (always 1 when req)
O_obi_be  output  4  OBI byte enables (4'hF when req)
O_obi_wdata  output  pINSTR_WIDTH  OBI write data
I_obi_rvalid  input  1  OBI response valid
O_busy  output  1  high in any state except IDLE
O_word_count  output  pCNT_WIDTH  words written since last address load
O_error  output  1  sticky misaligned-address flag

Behaviour:
- Reset values:
  - strobes=1
  - req/we=0; be/addr/wdata=0
  - busy=0, word_count=0, error=0
  - pointer=0
  - state=IDLE
- Reset mid-transaction aborts immediately (req drops next edge); flags are not cleared.
- States: IDLE, LOAD_ADDR, REQ, RESP, CLR_INSTR, WAIT_ADDR_LOW, WAIT_INSTR_LOW.
- IDLE: acts only if I_status[0]=1. addr_valid has priority over instr_valid when both are high.
  - addr_valid=1 -> LOAD_ADDR.
  - else instr_valid=1 -> REQ; latch I_instruction into wdata.
- LOAD_ADDR (1 cycle):
  - Pointer <= {I_address[W-1:2],2'b00}.
  - If I_address[1:0]!=0, set error (sticky until reset).
  - word_count<=0; O_reset_new_addr_valid=0 for this cycle -> WAIT_ADDR_LOW.
- WAIT_ADDR_LOW: stay until I_status[2]=0 (register block clears one cycle after the strobe), then -> IDLE. This prevents a double load.
- REQ:
  - req=1, addr=pointer, we=1, be=F; hold all stable until gnt.
  - gnt in same cycle -> RESP next cycle.
  - Minimum: the request is visible 1 cycle after IDLE sees instr_valid.
- RESP: req=0; wait for rvalid, which may arrive in the cycle after gnt or later. On rvalid: pointer+=4 (wraps mod 2^W), word_count+=1 (wraps), -> CLR_INSTR.
- CLR_INSTR (1 cycle): O_reset_instr_valid=0 -> WAIT_INSTR_LOW.
- WAIT_INSTR_LOW: stay until I_status[1]=0, then -> IDLE.
- prog_enable dropping while busy: the current transaction completes; no new one starts.
- Instruction/address changes after latch are ignored for the current write.
- Strobes are never asserted simultaneously; each lasts exactly one cycle.

Decomposition:
- Status bit indices (STATUS_PROG_EN=0, STATUS_INSTR_VALID=1, STATUS_ADDR_VALID=2) go in the shared defines include alongside the register addresses, so register block, bridge and host scripts agree.
- State encoding stays local.
- No sub-module; a single FSM plus pointer/counter registers (~200 lines).

Test Plan:
- Reset state: reset_i high 3 cycles -> all outputs at reset values, strobes high, busy=0.
- Address load:
  - status=8'h05, address=32'h0000_0100 -> new_addr strobe low exactly 1 cycle, word_count=0.
  - Status cleared next cycle -> IDLE, no second strobe.
- Single write:
  - After pointer=0x100, status=8'h03, instruction=32'hDEADBEEF, gnt tied 1, rvalid 1 cycle after gnt.
  - Expect req with addr=0x100, wdata=DEADBEEF, be=F, then instr strobe, word_count=1.
  - Next write goes to 0x104.
- Stalled grant:
  - gnt low 5 cycles -> req, addr and wdata held stable for all 6 cycles.
  - Exactly one write.
- Priority and misalignment:
  - status=8'h07, address=0x103 -> address loads first (pointer=0x100, error=1), then the instruction write at 0x100.
- Reset mid-RESP: reset_i during RESP -> req=0, state IDLE, counters 0, no clear strobe emitted.
